// File: rtl/mxint8_bd_ref_mon_if.sv
// Bus bundle for the MXINT8 broadcast reference monitor: operand, converter
// result under test, and the registered reference/check results.
interface mxint8_bd_ref_mon_if #(
    parameter int BLOCK_SIZE  = 32,
    parameter int SCALE_WIDTH = 8,
    parameter int ELEM_WIDTH  = 8,
    parameter int CNT_WIDTH   = 16
);
    logic                             i_valid;
    logic [31:0]                      i_float32;
    logic [SCALE_WIDTH-1:0]           i_dut_scale;
    logic [BLOCK_SIZE*ELEM_WIDTH-1:0] i_dut_elements;
    logic                             o_valid;
    logic [SCALE_WIDTH-1:0]           o_scale;
    logic [BLOCK_SIZE*ELEM_WIDTH-1:0] o_mxint8_elements;
    logic                             o_overflow;
    logic                             o_mismatch;
    logic [CNT_WIDTH-1:0]             o_check_cnt;
    logic [CNT_WIDTH-1:0]             o_err_cnt;

    modport master (
        output i_valid, i_float32, i_dut_scale, i_dut_elements,
        input  o_valid, o_scale, o_mxint8_elements, o_overflow,
               o_mismatch, o_check_cnt, o_err_cnt
    );

    modport slave (
        input  i_valid, i_float32, i_dut_scale, i_dut_elements,
        output o_valid, o_scale, o_mxint8_elements, o_overflow,
               o_mismatch, o_check_cnt, o_err_cnt
    );
endinterface

// File: rtl/mxint8_bd_ref_mon.sv
// Golden float32 -> MXINT8 broadcast converter with a one-cycle registered
// comparison against the converter under test and saturating counters.
module mxint8_bd_ref_mon #(
    parameter int BLOCK_SIZE  = 32,
    parameter int SCALE_WIDTH = 8,
    parameter int ELEM_WIDTH  = 8,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    mxint8_bd_ref_mon_if.slave   bus
);

    // Round the 1.6 magnitude to nearest-even; bit 8 flags saturation at 128.
    function automatic logic [8:0] rne_mag(input logic [22:0] man);
        logic [7:0] mag;
        logic       inc;
        inc = man[16] & ((|man[15:0]) | man[17]);
        mag = {2'b01, man[22:17]} + {7'b0000000, inc};
        if (mag == 8'd128) begin
            rne_mag = {1'b1, 8'd127};
        end else begin
            rne_mag = {1'b0, mag};
        end
    endfunction

    logic [7:0]                       exp_s;
    logic [8:0]                       rnd_s;
    logic [SCALE_WIDTH-1:0]           ref_scale_s;
    logic [ELEM_WIDTH-1:0]            ref_elem_s;
    logic                             ref_ovf_s;
    logic                             is_nan_s;
    logic [BLOCK_SIZE*ELEM_WIDTH-1:0] ref_elems_s;
    logic                             mismatch_s;

    logic                             valid_r;
    logic [SCALE_WIDTH-1:0]           scale_r;
    logic [BLOCK_SIZE*ELEM_WIDTH-1:0] elems_r;
    logic                             ovf_r;
    logic                             mismatch_r;
    logic [CNT_WIDTH-1:0]             check_cnt_r;
    logic [CNT_WIDTH-1:0]             err_cnt_r;

    // Reference conversion of the current operand and comparison with the DUT.
    always_comb begin
        exp_s       = bus.i_float32[30:23];
        rnd_s       = rne_mag(bus.i_float32[22:0]);
        ref_scale_s = 8'h00;
        ref_elem_s  = 8'h00;
        ref_ovf_s   = 1'b0;
        is_nan_s    = 1'b0;
        case (exp_s)
            8'h00: begin
                ref_scale_s = 8'h00;
                ref_elem_s  = 8'h00;
            end
            8'hFF: begin
                ref_scale_s = 8'hFF;
                is_nan_s    = 1'b1;
            end
            default: begin
                ref_scale_s = exp_s;
                ref_ovf_s   = rnd_s[8];
                if (bus.i_float32[31]) begin
                    ref_elem_s = 8'd0 - rnd_s[7:0];
                end else begin
                    ref_elem_s = rnd_s[7:0];
                end
            end
        endcase
        ref_elems_s = {BLOCK_SIZE{ref_elem_s}};
        // Element payload of an Inf/NaN block carries no meaning.
        mismatch_s  = (bus.i_dut_scale != ref_scale_s) |
                      (~is_nan_s & (bus.i_dut_elements != ref_elems_s));
    end

    // Output registers and saturating check/error counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r     <= 1'b0;
            scale_r     <= '0;
            elems_r     <= '0;
            ovf_r       <= 1'b0;
            mismatch_r  <= 1'b0;
            check_cnt_r <= '0;
            err_cnt_r   <= '0;
        end else begin
            valid_r <= bus.i_valid;
            if (bus.i_valid) begin
                scale_r    <= ref_scale_s;
                elems_r    <= ref_elems_s;
                ovf_r      <= ref_ovf_s;
                mismatch_r <= mismatch_s;
                if (check_cnt_r != {CNT_WIDTH{1'b1}}) begin
                    check_cnt_r <= check_cnt_r + CNT_WIDTH'(1);
                end
                if (mismatch_s && (err_cnt_r != {CNT_WIDTH{1'b1}})) begin
                    err_cnt_r <= err_cnt_r + CNT_WIDTH'(1);
                end
            end else begin
                mismatch_r <= 1'b0;
            end
        end
    end

    assign bus.o_valid           = valid_r;
    assign bus.o_scale           = scale_r;
    assign bus.o_mxint8_elements = elems_r;
    assign bus.o_overflow        = ovf_r;
    assign bus.o_mismatch        = mismatch_r;
    assign bus.o_check_cnt       = check_cnt_r;
    assign bus.o_err_cnt         = err_cnt_r;

endmodule

// File: tb/tb_mxint8_bd_ref_mon.sv
// Self-checking bench for mxint8_bd_ref_mon: directed cases plus random
// operands checked against an arithmetic reference of the MXINT8 conversion.
module tb_mxint8_bd_ref_mon;

    localparam int BS = 32;
    localparam int EW = BS * 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    mxint8_bd_ref_mon_if #(.BLOCK_SIZE(BS), .SCALE_WIDTH(8), .ELEM_WIDTH(8), .CNT_WIDTH(16)) bus ();

    mxint8_bd_ref_mon #(.BLOCK_SIZE(BS), .SCALE_WIDTH(8), .ELEM_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // expected registered state
    logic          x_valid;
    logic [7:0]    x_scale;
    logic [EW-1:0] x_elems;
    logic          x_ovf;
    logic          x_mis;
    int            x_chk;
    int            x_err;

    task automatic check_val(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Conversion from the number's value: |x| * 2^(6 - (e-127)) rounded half-even.
    task automatic model(input logic [31:0] f, output logic [7:0] sc,
                         output logic [7:0] el, output logic ov, output logic nan);
        int unsigned mant24, q, r;
        int          v;
        sc = 8'h00; el = 8'h00; ov = 1'b0; nan = 1'b0;
        if (f[30:23] == 8'd255) begin
            sc  = 8'hFF;
            nan = 1'b1;
        end else if (f[30:23] != 8'd0) begin
            sc     = f[30:23];
            mant24 = 32'h0080_0000 | {9'd0, f[22:0]};
            q      = mant24 / 131072;
            r      = mant24 % 131072;
            if (r > 65536 || (r == 65536 && (q % 2) == 1)) q = q + 1;
            if (q > 127) begin
                q  = 127;
                ov = 1'b1;
            end
            v  = f[31] ? -int'(q) : int'(q);
            el = v[7:0];
        end
    endtask

    // One cycle: drive inputs, advance, update expectations, compare all outputs.
    // corrupt: 0 none, 1 flip scale bits, 2 flip bits of one element.
    task automatic step(input logic v, input logic [31:0] f, input int corrupt, input logic r);
        logic [7:0]    sc, el, ds;
        logic          ov, nan, mis;
        logic [EW-1:0] de, ref_e;
        int            k;
        model(f, sc, el, ov, nan);
        for (int i = 0; i < BS; i++) ref_e[i*8 +: 8] = el;
        ds = sc;
        de = ref_e;
        if (nan) begin
            for (int i = 0; i < BS; i++) de[i*8 +: 8] = 8'($urandom);
        end
        if (corrupt == 1) ds = sc ^ 8'($urandom_range(1, 255));
        if (corrupt == 2) begin
            k = $urandom_range(0, BS - 1);
            de[k*8 +: 8] = de[k*8 +: 8] ^ 8'($urandom_range(1, 255));
        end
        mis = (ds != sc) || (!nan && de != ref_e);

        @(negedge clk);
        rst                = r;
        bus.i_valid        = v;
        bus.i_float32      = f;
        bus.i_dut_scale    = ds;
        bus.i_dut_elements = de;
        @(posedge clk);
        #1;
        if (r) begin
            x_valid = 1'b0; x_scale = 8'h00; x_elems = '0; x_ovf = 1'b0;
            x_mis = 1'b0; x_chk = 0; x_err = 0;
        end else begin
            x_valid = v;
            if (v) begin
                x_scale = sc; x_elems = ref_e; x_ovf = ov; x_mis = mis;
                if (x_chk < 65535) x_chk++;
                if (mis && x_err < 65535) x_err++;
            end else begin
                x_mis = 1'b0;
            end
        end
        check_val("o_valid",    EW'(bus.o_valid),     EW'(x_valid));
        check_val("o_scale",    EW'(bus.o_scale),     EW'(x_scale));
        check_val("o_elements", bus.o_mxint8_elements, x_elems);
        check_val("o_overflow", EW'(bus.o_overflow),  EW'(x_ovf));
        check_val("o_mismatch", EW'(bus.o_mismatch),  EW'(x_mis));
        check_val("o_check_cnt", EW'(bus.o_check_cnt), EW'(x_chk));
        check_val("o_err_cnt",  EW'(bus.o_err_cnt),   EW'(x_err));
    endtask

    logic [31:0] rf;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.i_valid = 1'b0; bus.i_float32 = 32'd0;
        bus.i_dut_scale = 8'd0; bus.i_dut_elements = '0;
        x_valid = 1'b0; x_scale = 8'h00; x_elems = '0; x_ovf = 1'b0;
        x_mis = 1'b0; x_chk = 0; x_err = 0;

        step(1'b1, 32'h3F80_0000, 0, 1'b1);
        step(1'b0, 32'h0000_0000, 0, 1'b1);

        // literal checks for the headline cases, independent of the model
        step(1'b1, 32'h3F80_0000, 0, 1'b0);
        check_val("lit_1p0_scale", EW'(bus.o_scale), EW'(8'h7F));
        check_val("lit_1p0_e0",    EW'(bus.o_mxint8_elements[7:0]), EW'(8'h40));
        step(1'b1, 32'hBFC0_0000, 0, 1'b0);
        check_val("lit_m1p5_e31",  EW'(bus.o_mxint8_elements[EW-1 -: 8]), EW'(8'hA0));
        step(1'b1, 32'hC020_0000, 0, 1'b0);
        check_val("lit_m2p5",      EW'({bus.o_scale, bus.o_mxint8_elements[7:0]}), EW'(16'h80B0));
        step(1'b1, 32'h3F81_0000, 0, 1'b0);
        check_val("lit_tie_even",  EW'(bus.o_mxint8_elements[15:8]), EW'(8'h40));
        step(1'b1, 32'h3F83_0000, 0, 1'b0);
        check_val("lit_tie_odd",   EW'(bus.o_mxint8_elements[15:8]), EW'(8'h42));
        step(1'b1, 32'h3FFF_FFFF, 0, 1'b0);
        check_val("lit_sat",       EW'({bus.o_overflow, bus.o_mxint8_elements[7:0]}), EW'(9'h17F));
        step(1'b1, 32'h0000_0000, 0, 1'b0);
        step(1'b1, 32'h8000_0001, 0, 1'b0);
        step(1'b1, 32'h7F80_0000, 0, 1'b0);
        check_val("lit_inf_scale", EW'(bus.o_scale), EW'(8'hFF));
        step(1'b1, 32'h7FC0_0000, 0, 1'b0);
        step(1'b1, 32'h7FC0_0000, 2, 1'b0);

        // error injection then idle
        step(1'b1, 32'h3F80_0000, 1, 1'b0);
        step(1'b1, 32'h3F80_0000, 2, 1'b0);
        check_val("lit_err_cnt",   EW'(bus.o_err_cnt), EW'(16'd2));
        step(1'b0, 32'h3F80_0000, 1, 1'b0);
        step(1'b0, 32'h4000_0000, 0, 1'b0);
        step(1'b1, 32'h7F80_0000, 1, 1'b0);

        // back-to-back with a reset in the middle
        for (int i = 0; i < 10; i++) begin
            step(1'b1, $urandom, 0, (i == 5) ? 1'b1 : 1'b0);
        end
        check_val("lit_post_rst_cnt", EW'(bus.o_check_cnt), EW'(16'd4));

        // random traffic, exponents biased toward the special encodings
        for (int i = 0; i < 400; i++) begin
            rf = $urandom;
            case ($urandom_range(0, 7))
                0: rf[30:23] = 8'h00;
                1: rf[30:23] = 8'hFF;
                2: rf[22:16] = 7'h7F;
                default: rf = rf;
            endcase
            step(($urandom_range(0, 3) != 0), rf, $urandom_range(0, 3) % 3,
                 ($urandom_range(0, 99) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
